ceespu_gshare_btb_predictor: RTL and testbench



---
 rtl/ceespu_gshare_btb_predictor.sv | 168 ++++++++++++++++
 tb/tb_ceespu_gshare_btb_predictor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ceespu_gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped BTB, speculative global history
// and mispredict recovery. A self-timed sweep clears the counter table after reset.
`timescale 1ns/1ps

module ceespu_gshare_btb_predictor #(
  parameter int INDEX_BITS = 8,
  parameter int HIST_BITS  = 8,
  parameter int BTB_BITS   = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic                  pred_hit,
  output logic [ADDR_WIDTH-1:0] pred_target,
  output logic [1:0]            pred_state,
  output logic [HIST_BITS-1:0]  pred_history,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_cond,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic [1:0]            upd_state,
  input  logic [HIST_BITS-1:0]  upd_history,
  input  logic                  upd_mispredict
);

  localparam int PHT_SIZE = 1 << INDEX_BITS;
  localparam int BTB_SIZE = 1 << BTB_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - BTB_BITS - 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state, state_next;
  logic [INDEX_BITS-1:0]   init_cnt;
  logic [HIST_BITS-1:0]    history;

  logic [1:0]              pht [PHT_SIZE];
  logic [BTB_SIZE-1:0]     btb_valid;
  logic [TAG_BITS-1:0]     btb_tag    [BTB_SIZE];
  logic [ADDR_WIDTH-1:0]   btb_target [BTB_SIZE];
  logic                    btb_cond   [BTB_SIZE];

  logic                    pred_cond;
  logic                    accept;
  logic [INDEX_BITS-1:0]   lk_idx;
  logic [BTB_BITS-1:0]     lk_btb;
  logic [TAG_BITS-1:0]     lk_tag;
  logic                    lk_hit;
  logic [1:0]              lk_state;
  logic                    lk_taken;

  logic                    upd_go;
  logic [INDEX_BITS-1:0]   upd_idx;
  logic [BTB_BITS-1:0]     upd_btb;
  logic [TAG_BITS-1:0]     upd_tag;
  logic [1:0]              upd_new_state;
  logic [HIST_BITS-1:0]    spec_hist;
  logic [HIST_BITS-1:0]    rec_hist;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (&init_cnt) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                init_cnt <= '0;
    else if (state == INIT) init_cnt <= init_cnt + 1'b1;
  end

  assign ready  = (state == RUN);
  assign accept = fetch_valid && ready;
  assign upd_go = upd_valid && ready;

  // Lookup path: arrays are read combinationally and captured at the edge,
  // so a same-cycle update is seen only by the following lookup.
  always_comb begin
    lk_idx   = fetch_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(history);
    lk_btb   = fetch_pc[BTB_BITS+1:2];
    lk_tag   = fetch_pc[ADDR_WIDTH-1:BTB_BITS+2];
    lk_hit   = btb_valid[lk_btb] && (btb_tag[lk_btb] == lk_tag);
    lk_state = pht[lk_idx];
    lk_taken = lk_hit && (!btb_cond[lk_btb] || lk_state[1]);
  end

  always_comb begin
    upd_idx = upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(upd_history);
    upd_btb = upd_pc[BTB_BITS+1:2];
    upd_tag = upd_pc[ADDR_WIDTH-1:BTB_BITS+2];
    upd_new_state = upd_state;
    if (upd_taken && upd_state != 2'd3)      upd_new_state = upd_state + 2'd1;
    else if (!upd_taken && upd_state != 2'd0) upd_new_state = upd_state - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (state == INIT)           pht[init_cnt] <= 2'd1;
    else if (upd_go && upd_cond) pht[upd_idx]  <= upd_new_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      btb_valid <= '0;
    else if (upd_go && upd_taken) btb_valid[upd_btb] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (upd_go && upd_taken) begin
      btb_tag[upd_btb]    <= upd_tag;
      btb_target[upd_btb] <= upd_target;
      btb_cond[upd_btb]   <= upd_cond;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pred_hit     <= 1'b0;
      pred_cond    <= 1'b0;
      pred_target  <= '0;
      pred_state   <= '0;
      pred_history <= '0;
    end else begin
      pred_valid <= accept;
      pred_hit   <= accept && lk_hit;
      pred_taken <= accept && lk_taken;
      pred_cond  <= accept && lk_hit && btb_cond[lk_btb];
      if (accept) begin
        pred_target  <= lk_hit ? btb_target[lk_btb] : '0;
        pred_state   <= lk_state;
        pred_history <= history;
      end
    end
  end

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign spec_hist = pred_taken;
      assign rec_hist  = upd_cond ? upd_taken : upd_history;
    end else begin : g_histn
      assign spec_hist = {history[HIST_BITS-2:0], pred_taken};
      assign rec_hist  = upd_cond ? {upd_history[HIST_BITS-2:0], upd_taken} : upd_history;
    end
  endgenerate

  // Recovery from execute outranks a speculative shift landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                history <= '0;
    else if (upd_go && upd_mispredict)      history <= rec_hist;
    else if (pred_valid && pred_hit && pred_cond) history <= spec_hist;
  end

endmodule

// File: tb/tb_ceespu_gshare_btb_predictor.sv
// Directed bench for ceespu_gshare_btb_predictor: init sweep, training, BTB,
// history shift/recovery, read-before-write collision and mid-sweep reset.
`timescale 1ns/1ps

module tb_ceespu_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic        pred_valid, pred_taken, pred_hit;
  logic [15:0] pred_target;
  logic [1:0]  pred_state;
  logic [7:0]  pred_history;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = '0;
  logic        upd_cond = 1'b0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = '0;
  logic [1:0]  upd_state = '0;
  logic [7:0]  upd_history = '0;
  logic        upd_mispredict = 1'b0;

  int checks = 0;
  int failures = 0;
  int init_bad = 0;
  int n_cycles;

  ceespu_gshare_btb_predictor dut (
    .clk(clk), .rst(rst), .ready(ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hit(pred_hit),
    .pred_target(pred_target), .pred_state(pred_state), .pred_history(pred_history),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cond(upd_cond), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_state(upd_state), .upd_history(upd_history),
    .upd_mispredict(upd_mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [15:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic update(input logic [15:0] pc, input logic cond, input logic taken,
                        input logic [15:0] tgt, input logic [1:0] st,
                        input logic [7:0] hist, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_cond = cond; upd_taken = taken;
    upd_target = tgt; upd_state = st; upd_history = hist; upd_mispredict = mis;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 400) begin
      tick();
      cycles++;
      if (pred_valid) init_bad++;
    end
  endtask

  task automatic check_pred(input string tag, input logic v, input logic h, input logic t,
                            input logic [15:0] tgt, input logic [1:0] st, input logic [7:0] hs);
    check({tag, ".valid"},   32'(pred_valid),   32'(v));
    check({tag, ".hit"},     32'(pred_hit),     32'(h));
    check({tag, ".taken"},   32'(pred_taken),   32'(t));
    check({tag, ".target"},  32'(pred_target),  32'(tgt));
    check({tag, ".state"},   32'(pred_state),   32'(st));
    check({tag, ".history"}, 32'(pred_history), 32'(hs));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] start");
    repeat (3) tick();
    check("rst.ready", 32'(ready), 32'd0);
    check_pred("rst", 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 8'h00);

    // Traffic during the sweep must be ignored entirely
    fetch_valid = 1'b1; fetch_pc = 16'h0040;
    upd_valid = 1'b1; upd_pc = 16'h0040; upd_cond = 1'b1; upd_taken = 1'b1;
    upd_target = 16'hFFFC; upd_state = 2'd1; upd_history = 8'hAA; upd_mispredict = 1'b1;
    rst = 1'b0;
    wait_ready(n_cycles);
    fetch_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    check("init.cycles", 32'(n_cycles), 32'd256);
    check("init.no_pred", 32'(init_bad), 32'd0);

    lookup(16'h0040);
    check_pred("boot", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'h00);
    lookup(16'h1234);
    check_pred("boot2", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'h00);

    update(16'h0040, 1'b1, 1'b1, 16'h0100, 2'd1, 8'h00, 1'b0);
    update(16'h0040, 1'b1, 1'b1, 16'h0100, 2'd2, 8'h00, 1'b0);
    update(16'h0040, 1'b1, 1'b1, 16'h0100, 2'd3, 8'h00, 1'b0);
    lookup(16'h0040);
    check_pred("train", 1'b1, 1'b1, 1'b1, 16'h0100, 2'd3, 8'h00);
    tick();
    check("drop.valid",  32'(pred_valid),  32'd0);
    check("drop.hit",    32'(pred_hit),    32'd0);
    check("drop.taken",  32'(pred_taken),  32'd0);
    check("drop.target", 32'(pred_target), 32'h0100);
    check("drop.state",  32'(pred_state),  32'd3);

    // History is now 0x01 after the hitting conditional lookup above
    update(16'h0080, 1'b0, 1'b1, 16'h0200, 2'd1, 8'h00, 1'b0);
    lookup(16'h0080);
    check_pred("uncond", 1'b1, 1'b1, 1'b1, 16'h0200, 2'd1, 8'h01);
    update(16'h0104, 1'b1, 1'b0, 16'h0999, 2'd1, 8'h00, 1'b0);
    lookup(16'h0104);
    check_pred("nt_upd", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'h01);

    update(16'h0300, 1'b0, 1'b0, 16'h0000, 2'd0, 8'h00, 1'b1);
    update(16'h0048, 1'b1, 1'b1, 16'h0400, 2'd2, 8'h00, 1'b0);
    update(16'h004C, 1'b1, 1'b1, 16'h0500, 2'd0, 8'h00, 1'b0);
    lookup(16'h0048);
    check_pred("histA", 1'b1, 1'b1, 1'b1, 16'h0400, 2'd3, 8'h00);
    lookup(16'h004C);
    check_pred("histB", 1'b1, 1'b1, 1'b0, 16'h0500, 2'd1, 8'h00);
    tick();
    lookup(16'h2000);
    check_pred("hist10", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'h02);

    lookup(16'h0048);
    check_pred("recA", 1'b1, 1'b1, 1'b1, 16'h0400, 2'd3, 8'h02);
    update(16'h3000, 1'b1, 1'b1, 16'h0600, 2'd1, 8'h01, 1'b1);
    lookup(16'h2000);
    check_pred("recover", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'h03);

    fetch_valid = 1'b1; fetch_pc = 16'h0500;
    upd_valid = 1'b1; upd_pc = 16'h0500; upd_cond = 1'b1; upd_taken = 1'b1;
    upd_target = 16'h0700; upd_state = 2'd1; upd_history = 8'h03; upd_mispredict = 1'b0;
    tick();
    fetch_valid = 1'b0; upd_valid = 1'b0;
    check_pred("collide", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'h03);
    lookup(16'h0500);
    check_pred("collide2", 1'b1, 1'b1, 1'b1, 16'h0700, 2'd2, 8'h03);

    rst = 1'b1;
    #1;
    check("arst.ready", 32'(ready), 32'd0);
    check_pred("arst", 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 8'h00);
    tick(); tick();
    rst = 1'b0;
    repeat (100) tick();
    check("mid.ready", 32'(ready), 32'd0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wait_ready(n_cycles);
    check("reinit.cycles", 32'(n_cycles), 32'd256);
    lookup(16'h0500);
    check_pred("post_rst", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'h00);
    lookup(16'h0048);
    check_pred("post_rst2", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
